// File: rtl/vec_pkg.sv
// ============================================================================
// Module : vec_pkg
// Brief  : Shared types and constants for the vector issue sequencer:
//          opcode encoding, sequencer states, register-file geometry.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vec_pkg;

  localparam int NREG       = 32;
  localparam int REG_W      = $clog2(NREG);
  localparam int NCHUNK_DEF = 4;

  typedef enum logic [2:0] {
    VXOR     = 3'd0,
    VMACC    = 3'd1,
    VREDSUM  = 3'd2,
    VSLIDEUP = 3'd3,
    VRGATHER = 3'd4
  } vop_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    EX   = 3'd2,
    WB   = 3'd3,
    RSP  = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/vec_op_legal.sv
// ============================================================================
// Module : vec_op_legal
// Brief  : Combinational legality check of an offered vector instruction.
//          Ports: op/vd/vs1/vs2/lmul in, err out (1 = reject).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vec_op_legal
  import vec_pkg::*;
(
  input  logic [2:0]       op,
  input  logic [REG_W-1:0] vd,
  input  logic [REG_W-1:0] vs1,
  input  logic [REG_W-1:0] vs2,
  input  logic             lmul,
  output logic             err
);

  logic w_bad_op;
  logic w_red;
  logic w_misalign;
  logic w_slide_ovl;

  always_comb begin
    w_bad_op    = (op > VRGATHER);
    // vredsum reduces into a single scalar element, so vd/vs1 are single
    // registers even in a group and need no group alignment.
    w_red       = (op == VREDSUM);
    w_misalign  = lmul && (((vd[1:0]  != 2'b00) && !w_red) ||
                           ((vs1[1:0] != 2'b00) && !w_red) ||
                            (vs2[1:0] != 2'b00));
    w_slide_ovl = (op == VSLIDEUP) && (vd == vs2);
    err         = w_bad_op || w_misalign || w_slide_ovl;
  end

endmodule

`default_nettype wire

// File: rtl/vec_issue_ctrl.sv
// ============================================================================
// Module : vec_issue_ctrl
// Brief  : Vector issue sequencer. Accepts one instruction over ins_valid/
//          ins_ready, checks legality, walks RD -> EX -> WB once per pass
//          (NCHUNK passes for grouped element-wise ops) and answers over
//          rsp_valid/rsp_ready with rsp_err.
//          Ports: vsi_clk, vsi_rst (sync, active-high); ins_* instruction
//          port; exec_en, is_* op select, *_addr operand ids, uimm,
//          vsi_lmul, vsi_sew, rf_we to the datapath; rsp_* response port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vec_issue_ctrl
  import vec_pkg::*;
#(
  parameter int NCHUNK   = NCHUNK_DEF,
  parameter int EXEC_LAT = 1,
  parameter int MAC_LAT  = 2
) (
  input  logic             vsi_clk,
  input  logic             vsi_rst,
  input  logic             ins_valid,
  output logic             ins_ready,
  input  logic [2:0]       ins_op,
  input  logic [REG_W-1:0] ins_vd,
  input  logic [REG_W-1:0] ins_vs1,
  input  logic [REG_W-1:0] ins_vs2,
  input  logic [REG_W-1:0] ins_uimm,
  input  logic             ins_lmul,
  input  logic             ins_sew,
  output logic             exec_en,
  output logic             is_vxor,
  output logic             is_vmacc,
  output logic             is_vredsum,
  output logic             is_vslideup,
  output logic             is_vrgather,
  output logic [REG_W-1:0] vd_addr,
  output logic [REG_W-1:0] vs1_addr,
  output logic [REG_W-1:0] vs2_addr,
  output logic [REG_W-1:0] uimm,
  output logic             vsi_lmul,
  output logic             vsi_sew,
  output logic             rf_we,
  output logic             rsp_valid,
  output logic             rsp_err,
  input  logic             rsp_ready
);

  localparam int PASS_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int LAT_MAX = (MAC_LAT > EXEC_LAT) ? MAC_LAT : EXEC_LAT;
  localparam int LAT_W   = $clog2(LAT_MAX + 1);

  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NCHUNK - 1);
  localparam logic [LAT_W-1:0]  EXEC_LAST = LAT_W'(EXEC_LAT - 1);
  localparam logic [LAT_W-1:0]  MAC_LAST  = LAT_W'(MAC_LAT - 1);

  state_e            r_state;
  state_e            w_next;
  logic [2:0]        r_op;
  logic [REG_W-1:0]  r_vd;
  logic [REG_W-1:0]  r_vs1;
  logic [REG_W-1:0]  r_vs2;
  logic [REG_W-1:0]  r_uimm;
  logic              r_lmul;
  logic              r_sew;
  logic              r_err;
  logic [PASS_W-1:0] r_pass;
  logic [LAT_W-1:0]  r_lat;

  logic w_err;
  logic w_accept;
  logic w_multi;
  logic w_last;
  logic w_sel;

  vec_op_legal u_legal (
    .op   (ins_op),
    .vd   (ins_vd),
    .vs1  (ins_vs1),
    .vs2  (ins_vs2),
    .lmul (ins_lmul),
    .err  (w_err)
  );

  assign w_accept = ins_valid && (r_state == IDLE);
  // Only grouped element-wise ops iterate; everything else is one pass.
  assign w_multi  = r_lmul && ((r_op == VXOR) || (r_op == VMACC));
  assign w_last   = !w_multi || (r_pass == LAST_PASS);

  always_ff @(posedge vsi_clk) begin
    if (vsi_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    ins_ready = 1'b0;
    exec_en   = 1'b0;
    rf_we     = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    w_sel     = 1'b0;
    case (r_state)
      IDLE: begin
        ins_ready = 1'b1;
        if (ins_valid) w_next = w_err ? RSP : RD;
      end
      RD: begin
        w_sel  = 1'b1;
        w_next = EX;
      end
      EX: begin
        w_sel   = 1'b1;
        exec_en = 1'b1;
        if (r_lat == '0) w_next = WB;
      end
      WB: begin
        w_sel  = 1'b1;
        rf_we  = 1'b1;
        w_next = w_last ? RSP : RD;
      end
      RSP: begin
        rsp_valid = 1'b1;
        rsp_err   = r_err;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge vsi_clk) begin
    if (vsi_rst) begin
      r_op   <= '0;
      r_vd   <= '0;
      r_vs1  <= '0;
      r_vs2  <= '0;
      r_uimm <= '0;
      r_lmul <= 1'b0;
      r_sew  <= 1'b0;
      r_err  <= 1'b0;
      r_pass <= '0;
      r_lat  <= '0;
    end else begin
      if (w_accept) begin
        r_op   <= ins_op;
        r_vd   <= ins_vd;
        r_vs1  <= ins_vs1;
        r_vs2  <= ins_vs2;
        r_uimm <= ins_uimm;
        r_lmul <= ins_lmul;
        r_sew  <= ins_sew;
        r_err  <= w_err;
        r_pass <= '0;
      end
      // EX down-counter is armed in RD so it covers exactly LAT cycles.
      if (r_state == RD) begin
        r_lat <= (r_op == VMACC) ? MAC_LAST : EXEC_LAST;
      end else if ((r_state == EX) && (r_lat != '0)) begin
        r_lat <= r_lat - 1'b1;
      end
      if ((r_state == WB) && !w_last) begin
        r_pass <= r_pass + 1'b1;
      end
    end
  end

  assign is_vxor     = w_sel && (r_op == VXOR);
  assign is_vmacc    = w_sel && (r_op == VMACC);
  assign is_vredsum  = w_sel && (r_op == VREDSUM);
  assign is_vslideup = w_sel && (r_op == VSLIDEUP);
  assign is_vrgather = w_sel && (r_op == VRGATHER);

  // Grouped operands are 4-aligned, so adding the pass index never carries.
  assign vd_addr  = r_vd  + REG_W'(r_pass);
  assign vs1_addr = r_vs1 + REG_W'(r_pass);
  assign vs2_addr = r_vs2 + REG_W'(r_pass);
  assign uimm     = r_uimm;
  assign vsi_lmul = r_lmul;
  assign vsi_sew  = r_sew;

endmodule

`default_nettype wire

// File: tb/tb_vec_issue_ctrl.sv
// ============================================================================
// Module : tb_vec_issue_ctrl
// Brief  : Directed self-checking bench for vec_issue_ctrl with a queue
//          scoreboard of expected write-back operands and responses.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vec_issue_ctrl;

  logic       vsi_clk = 1'b0;
  logic       vsi_rst = 1'b1;
  logic       ins_valid = 1'b0;
  logic       ins_ready;
  logic [2:0] ins_op = '0;
  logic [4:0] ins_vd = '0, ins_vs1 = '0, ins_vs2 = '0, ins_uimm = '0;
  logic       ins_lmul = 1'b0, ins_sew = 1'b0;
  logic       exec_en, is_vxor, is_vmacc, is_vredsum, is_vslideup, is_vrgather;
  logic [4:0] vd_addr, vs1_addr, vs2_addr, uimm;
  logic       vsi_lmul, vsi_sew, rf_we, rsp_valid, rsp_err;
  logic       rsp_ready = 1'b1;

  int tests = 0;
  int fails = 0;
  int we_total = 0;
  logic [14:0] we_q[$];
  logic        rsp_q[$];
  logic [14:0] mon_we;
  logic        mon_rsp;

  always #5 vsi_clk = ~vsi_clk;

  vec_issue_ctrl #(.NCHUNK(4), .EXEC_LAT(1), .MAC_LAT(2)) dut (
    .vsi_clk(vsi_clk), .vsi_rst(vsi_rst),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_op(ins_op),
    .ins_vd(ins_vd), .ins_vs1(ins_vs1), .ins_vs2(ins_vs2), .ins_uimm(ins_uimm),
    .ins_lmul(ins_lmul), .ins_sew(ins_sew),
    .exec_en(exec_en), .is_vxor(is_vxor), .is_vmacc(is_vmacc),
    .is_vredsum(is_vredsum), .is_vslideup(is_vslideup), .is_vrgather(is_vrgather),
    .vd_addr(vd_addr), .vs1_addr(vs1_addr), .vs2_addr(vs2_addr),
    .uimm(uimm), .vsi_lmul(vsi_lmul), .vsi_sew(vsi_sew), .rf_we(rf_we),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_ready(rsp_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every write-back and every consumed response must
  // match the next expectation queued at issue time.
  always @(negedge vsi_clk) begin
    if (rf_we) begin
      we_total++;
      if (we_q.size() == 0) begin
        check("rf_we_unexpected", we_q.size(), 1);
      end else begin
        mon_we = we_q.pop_front();
        check("rf_we_operands", {vd_addr, vs1_addr, vs2_addr}, mon_we);
      end
    end
    if (rsp_valid && rsp_ready) begin
      if (rsp_q.size() == 0) begin
        check("rsp_unexpected", rsp_q.size(), 1);
      end else begin
        mon_rsp = rsp_q.pop_front();
        check("rsp_err", rsp_err, mon_rsp);
      end
    end
  end

  // Called at posedge+1 while the DUT is IDLE; returns at posedge+1 of cycle 1.
  task automatic issue(input logic [2:0] op, input logic [4:0] vd, vs1, vs2, im,
                       input logic lmul, sew, exp_err, input int npass, input bit push_rsp);
    for (int k = 0; k < npass; k++)
      we_q.push_back({5'(vd + k), 5'(vs1 + k), 5'(vs2 + k)});
    if (push_rsp) rsp_q.push_back(exp_err);
    ins_valid = 1'b1; ins_op = op; ins_vd = vd; ins_vs1 = vs1; ins_vs2 = vs2;
    ins_uimm = im; ins_lmul = lmul; ins_sew = sew;
    @(posedge vsi_clk); #1;
    ins_valid = 1'b0;
  endtask

  // Samples every cycle until rsp_valid (bounded) and checks the timeline.
  task automatic run_to_rsp(input string tag, input int exp_rsp, exp_fex, exp_exn,
                            exp_wen, input logic [4:0] exp_sel);
    int n = 0, f_ex = 0, ex_n = 0, we_n = 0;
    logic [4:0] sel = '0;
    do begin
      @(negedge vsi_clk); #1;
      n++;
      if (exec_en) begin
        ex_n++;
        if (f_ex == 0) begin
          f_ex = n;
          sel = {is_vrgather, is_vslideup, is_vredsum, is_vmacc, is_vxor};
        end
      end
      if (rf_we) we_n++;
    end while (!rsp_valid && n < 200);
    check({tag, "_rsp_cycle"}, n, exp_rsp);
    check({tag, "_first_exec"}, f_ex, exp_fex);
    check({tag, "_exec_cycles"}, ex_n, exp_exn);
    check({tag, "_rf_we_count"}, we_n, exp_wen);
    check({tag, "_op_select"}, sel, exp_sel);
  endtask

  initial begin
    int base;
    bit saw;
    repeat (3) @(posedge vsi_clk);
    #1;
    vsi_rst = 1'b0;
    @(negedge vsi_clk); #1;
    check("rst_ins_ready", ins_ready, 1);
    check("rst_exec_en", exec_en, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_addrs", {vd_addr, vs1_addr, vs2_addr, uimm}, 0);
    @(posedge vsi_clk); #1;

    // 1: single-register vxor
    issue(3'd0, 5'd3, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    run_to_rsp("t1_vxor", 4, 2, 1, 1, 5'b00001);
    @(posedge vsi_clk); #1;

    // 2: grouped vmacc, four passes of MAC_LAT=2
    issue(3'd1, 5'd8, 5'd4, 5'd12, 5'd0, 1'b1, 1'b1, 1'b0, 4, 1'b1);
    run_to_rsp("t2_vmacc4", 17, 2, 8, 4, 5'b00010);
    check("t2_lmul_out", vsi_lmul, 1);
    @(posedge vsi_clk); #1;

    // single-register vmacc
    issue(3'd1, 5'd1, 5'd2, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    run_to_rsp("t2b_vmacc1", 5, 2, 2, 1, 5'b00010);
    @(posedge vsi_clk); #1;

    // 3: misaligned group and illegal opcode
    issue(3'd0, 5'd5, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 0, 1'b1);
    run_to_rsp("t3_misalign", 1, 0, 0, 0, 5'b00000);
    @(posedge vsi_clk); #1;
    issue(3'd6, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    run_to_rsp("t3_badop", 1, 0, 0, 0, 5'b00000);
    @(posedge vsi_clk); #1;

    // 4: response back-pressure, then next instruction waits for IDLE
    rsp_ready = 1'b0;
    issue(3'd4, 5'd9, 5'd10, 5'd11, 5'd0, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    run_to_rsp("t4_vrgather", 4, 2, 1, 1, 5'b10000);
    we_q.push_back({5'd4, 5'd0, 5'd8});
    rsp_q.push_back(1'b0);
    ins_valid = 1'b1; ins_op = 3'd3; ins_vd = 5'd4; ins_vs1 = 5'd0; ins_vs2 = 5'd8;
    ins_uimm = 5'd17; ins_lmul = 1'b0; ins_sew = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge vsi_clk); #1;
      @(negedge vsi_clk); #1;
      check("t4_hold_valid", rsp_valid, 1);
      check("t4_hold_err", rsp_err, 0);
      check("t4_hold_ready", ins_ready, 0);
    end
    @(posedge vsi_clk); #1;
    rsp_ready = 1'b1;
    @(negedge vsi_clk); #1;
    check("t4_no_same_cycle_accept", ins_ready, 0);
    @(posedge vsi_clk); #1;
    @(negedge vsi_clk); #1;
    check("t4_idle_ready", ins_ready, 1);
    check("t4_idle_rsp_valid", rsp_valid, 0);
    @(posedge vsi_clk); #1;
    ins_valid = 1'b0;
    run_to_rsp("t4_vslideup", 4, 2, 1, 1, 5'b01000);
    check("t4_uimm", uimm, 17);
    check("t4_sew", vsi_sew, 1);
    @(posedge vsi_clk); #1;

    // 5: reset during the third pass of a grouped vmacc
    base = we_total;
    issue(3'd1, 5'd8, 5'd4, 5'd12, 5'd0, 1'b1, 1'b0, 1'b0, 2, 1'b0);
    repeat (9) @(posedge vsi_clk);
    #1;
    vsi_rst = 1'b1;
    @(posedge vsi_clk); #1;
    vsi_rst = 1'b0;
    @(negedge vsi_clk); #1;
    check("t5_ins_ready", ins_ready, 1);
    check("t5_exec_en", exec_en, 0);
    check("t5_vd_addr", vd_addr, 0);
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge vsi_clk); #1;
      if (rf_we || rsp_valid) saw = 1'b1;
    end
    check("t5_quiet_after_reset", saw, 0);
    check("t5_we_before_reset", we_total - base, 2);
    check("t5_we_queue_drained", we_q.size(), 0);
    @(posedge vsi_clk); #1;

    // 6: vslideup overlap rejected; grouped vredsum is a single legal pass
    issue(3'd3, 5'd7, 5'd0, 5'd7, 5'd1, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    run_to_rsp("t6_slide_ovl", 1, 0, 0, 0, 5'b00000);
    @(posedge vsi_clk); #1;
    issue(3'd2, 5'd2, 5'd1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1, 1'b1);
    run_to_rsp("t6_vredsum", 4, 2, 1, 1, 5'b00100);
    @(posedge vsi_clk); #1;
    @(negedge vsi_clk); #1;
    check("end_rsp_queue_drained", rsp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
